// File: rtl/hazard_pkg.sv
//==============================================================================
// Module      : hazard_pkg
// Description : Shared hazard encodings, shadow-record type and liveness helper
//               used by the hazard scoreboard and its forwarding selectors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package hazard_pkg;

    // Result type driven by the decoder; must match its hazard_optype encoding.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ALU  = 2'b10,
        OP_LOAD = 2'b11
    } optype_t;

    // Operand-mux source encoding shared with the ID-stage operand muxes.
    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_EX_ALU  = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU = 2'd2;
    localparam logic [1:0] FWD_MEM_LD  = 2'd3;

    typedef struct packed {
        logic [4:0] rd;
        logic [1:0] op;
    } rec_t;

    function automatic logic rec_live(input rec_t r);
        return (r.op != OP_NONE) && (r.rd != 5'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_select.sv
//==============================================================================
// Module      : fwd_select
// Description : Combinational forwarding-source selection for one operand.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fwd_select
    import hazard_pkg::*;
(
    input  logic       use_i,
    input  logic [4:0] rs_i,
    input  rec_t       ex_i,
    input  rec_t       mem_i,
    output logic [1:0] sel_o,
    output logic       ex_load_hit_o
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = use_i && (rs_i != 5'd0) && rec_live(ex_i)  && (ex_i.rd  == rs_i);
    assign w_mem_hit = use_i && (rs_i != 5'd0) && rec_live(mem_i) && (mem_i.rd == rs_i);

    assign ex_load_hit_o = w_ex_hit && (ex_i.op == OP_LOAD);

    // The younger EX writer shadows any MEM writer of the same register.
    always_comb begin
        sel_o = FWD_RF;
        if (w_ex_hit && (ex_i.op == OP_ALU)) begin
            sel_o = FWD_EX_ALU;
        end else if (w_mem_hit && (mem_i.op == OP_ALU)) begin
            sel_o = FWD_MEM_ALU;
        end else if (w_mem_hit && (mem_i.op == OP_LOAD)) begin
            sel_o = FWD_MEM_LD;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
//==============================================================================
// Module      : hazard_scoreboard
// Description : ID-stage forwarding selects, load-use stall, taken-branch flush
//               and saturating stall/flush event counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_rs1use,
    input  logic             id_rs2use,
    input  logic             id_regwrite,
    input  logic [1:0]       id_optype,
    input  logic             id_branch,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    rec_t             ex_q, ex_d;
    rec_t             mem_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [1:0]       w_sel_a, w_sel_b;
    logic             w_hit_a, w_hit_b;

    fwd_select u_fwd_a (
        .use_i         (id_rs1use),
        .rs_i          (id_rs1),
        .ex_i          (ex_q),
        .mem_i         (mem_q),
        .sel_o         (w_sel_a),
        .ex_load_hit_o (w_hit_a)
    );

    fwd_select u_fwd_b (
        .use_i         (id_rs2use),
        .rs_i          (id_rs2),
        .ex_i          (ex_q),
        .mem_i         (mem_q),
        .sel_o         (w_sel_b),
        .ex_load_hit_o (w_hit_b)
    );

    assign stall      = id_valid & (w_hit_a | w_hit_b);
    // A branch compared on stale operands during a stall re-resolves next cycle.
    assign flush_ifid = id_branch & id_valid & ~stall;
    assign fwd_a_sel  = stall ? FWD_RF : w_sel_a;
    assign fwd_b_sel  = stall ? FWD_RF : w_sel_b;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

    always_comb begin
        ex_d = '0;
        if (!stall && id_valid && id_regwrite && (id_rd != 5'd0)) begin
            ex_d.rd = id_rd;
            ex_d.op = id_optype;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + C_CNT_ONE;
        end
        if (flush_ifid && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + C_CNT_ONE;
        end
    end

    // WB is not shadowed: the register file is write-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
//==============================================================================
// Module      : tb_hazard_scoreboard
// Description : Scenario bench for hazard_scoreboard with an expected-output queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       rw;
        logic [1:0] op;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid, id_rs1use, id_rs2use, id_regwrite, id_branch;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [1:0]       id_optype;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             stall, flush_ifid;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_rs1use   (id_rs1use),
        .id_rs2use   (id_rs2use),
        .id_regwrite (id_regwrite),
        .id_optype   (id_optype),
        .id_branch   (id_branch),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall),
        .flush_ifid  (flush_ifid),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic u1, input logic u2,
                                 input logic rw, input logic [1:0] op, input logic br);
        stim_t s;
        s = '{v, rs1, rs2, rd, u1, u2, rw, op, br};
        return s;
    endfunction

    function automatic exp_t ex(input logic st, input logic fl, input logic [1:0] a, input logic [1:0] b);
        exp_t e;
        e = '{st, fl, a, b};
        return e;
    endfunction

    task automatic apply(input stim_t s);
        id_valid    = s.v;
        id_rs1      = s.rs1;
        id_rs2      = s.rs2;
        id_rd       = s.rd;
        id_rs1use   = s.u1;
        id_rs2use   = s.u2;
        id_regwrite = s.rw;
        id_optype   = s.op;
        id_branch   = s.br;
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply('0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        stim_t st[3];
        exp_t  e[3];
        exp_t  got, want;
        do_reset();
        st[0] = mk(1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 2'b00, 1);  e[0] = ex(0, 1, 0, 0);
        st[1] = mk(1, 5'd1, 5'd0, 5'd5, 1, 0, 1, 2'b11, 0);  e[1] = ex(0, 0, 0, 0);
        st[2] = mk(1, 5'd5, 5'd0, 5'd0, 1, 0, 0, 2'b00, 0);  e[2] = ex(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {stall, flush_ifid, fwd_a_sel, fwd_b_sel};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_pre step %0d: got %b want %b", i, got, want);
            end
        end
        checks++;
        if (flush_cnt !== 4'd1) begin
            errors++;
            $display("FAIL reset_pre_flush_cnt: got %0d want 1", flush_cnt);
        end
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        exp_q.push_back(ex(0, 0, 0, 0));
        got  = {stall, flush_ifid, fwd_a_sel, fwd_b_sel};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_post_outputs: got %b want %b", got, want);
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL reset_post_counters: got stall_cnt=%0d flush_cnt=%0d want 0 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_alu_chain();
        stim_t st[3];
        exp_t  e[3];
        exp_t  got, want;
        do_reset();
        st[0] = mk(1, 5'd1, 5'd2, 5'd3, 1, 1, 1, 2'b10, 0);  e[0] = ex(0, 0, 0, 0);
        st[1] = mk(1, 5'd3, 5'd3, 5'd4, 1, 1, 1, 2'b10, 0);  e[1] = ex(0, 0, 1, 1);
        st[2] = mk(1, 5'd3, 5'd0, 5'd0, 1, 0, 0, 2'b00, 0);  e[2] = ex(0, 0, 2, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {stall, flush_ifid, fwd_a_sel, fwd_b_sel};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL alu_chain step %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[3];
        exp_t  e[3];
        exp_t  got, want;
        do_reset();
        st[0] = mk(1, 5'd1, 5'd0, 5'd6, 1, 0, 1, 2'b11, 0);  e[0] = ex(0, 0, 0, 0);
        st[1] = mk(1, 5'd6, 5'd0, 5'd7, 1, 1, 1, 2'b10, 0);  e[1] = ex(1, 0, 0, 0);
        st[2] = st[1];                                       e[2] = ex(0, 0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {stall, flush_ifid, fwd_a_sel, fwd_b_sel};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use step %0d: got %b want %b", i, got, want);
            end
        end
        checks++;
        if (stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_x0_priority();
        stim_t st[5];
        exp_t  e[5];
        exp_t  got, want;
        do_reset();
        st[0] = mk(1, 5'd1, 5'd2, 5'd0, 1, 1, 1, 2'b10, 0);  e[0] = ex(0, 0, 0, 0);
        st[1] = mk(1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 2'b11, 0);  e[1] = ex(0, 0, 0, 0);
        st[2] = mk(1, 5'd1, 5'd0, 5'd8, 1, 0, 1, 2'b11, 0);  e[2] = ex(0, 0, 0, 0);
        st[3] = mk(1, 5'd1, 5'd2, 5'd8, 1, 1, 1, 2'b10, 0);  e[3] = ex(0, 0, 0, 0);
        st[4] = mk(1, 5'd8, 5'd8, 5'd0, 1, 1, 0, 2'b00, 0);  e[4] = ex(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {stall, flush_ifid, fwd_a_sel, fwd_b_sel};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL x0_priority step %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_branch();
        stim_t st[4];
        exp_t  e[4];
        exp_t  got, want;
        do_reset();
        st[0] = mk(1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 2'b00, 1);  e[0] = ex(0, 1, 0, 0);
        st[1] = mk(1, 5'd1, 5'd0, 5'd9, 1, 0, 1, 2'b11, 0);  e[1] = ex(0, 0, 0, 0);
        st[2] = mk(1, 5'd9, 5'd1, 5'd0, 1, 1, 0, 2'b00, 1);  e[2] = ex(1, 0, 0, 0);
        st[3] = st[2];                                       e[3] = ex(0, 1, 3, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {stall, flush_ifid, fwd_a_sel, fwd_b_sel};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch step %0d: got %b want %b", i, got, want);
            end
            if (i == 1) begin
                checks++;
                if (flush_cnt !== 4'd1) begin
                    errors++;
                    $display("FAIL branch_flush_cnt_first: got %0d want 1", flush_cnt);
                end
            end
        end
        @(posedge clk); #1;
        apply('0);
        checks++;
        if ({flush_cnt, stall_cnt} !== {4'd2, 4'd1}) begin
            errors++;
            $display("FAIL branch_counters: got flush_cnt=%0d stall_cnt=%0d want 2 1", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[4];
        exp_t  e[4];
        exp_t  got, want;
        do_reset();
        st[0] = mk(1, 5'd1, 5'd0, 5'd5, 1, 0, 1, 2'b10, 0);  e[0] = ex(0, 0, 0, 0);
        st[1] = mk(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 2'b11, 0);  e[1] = ex(0, 0, 0, 0);
        st[2] = mk(1, 5'd0, 5'd5, 5'd0, 0, 1, 0, 2'b00, 0);  e[2] = ex(1, 0, 0, 0);
        st[3] = st[2];                                       e[3] = ex(0, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = {stall, flush_ifid, fwd_a_sel, fwd_b_sel};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_saturation();
        stim_t s;
        exp_t  got, want;
        do_reset();
        // lw x10,0(x10) held in ID stalls on itself every other cycle.
        s = mk(1, 5'd10, 5'd0, 5'd10, 1, 0, 1, 2'b11, 0);
        for (int i = 0; i <= 40; i++) begin
            @(posedge clk); #1;
            apply(s);
            if (i == 0)          exp_q.push_back(ex(0, 0, 0, 0));
            else if (i % 2 == 1) exp_q.push_back(ex(1, 0, 0, 0));
            else                 exp_q.push_back(ex(0, 0, 3, 0));
            @(negedge clk);
            got  = {stall, flush_ifid, fwd_a_sel, fwd_b_sel};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL saturation step %0d: got %b want %b", i, got, want);
            end
        end
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL saturation_stall_cnt: got %0d want 15", stall_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply('0);
        test_reset();
        test_alu_chain();
        test_load_use();
        test_x0_priority();
        test_branch();
        test_back_to_back();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
